gate_truth_table_exerciser: RTL and testbench

Sequential stimulus/check stage that sits directly upstream of a mux-built logic gate (e.g. and_gate_using_mux) and drives it.
- Walks every input combination of an N-input combinational gate.
- Waits a programmable settle time per vector, samples the gate output and compares it against an expected truth table.
- Reports pass/fail, mismatch count and first failing vector index.
- Used as an on-chip self-check harness around the homework gate modules.

---
 rtl/gate_exerciser_pkg.sv | 22 ++
 rtl/gate_settle_timer.sv | 27 ++
 rtl/gate_truth_table_exerciser.sv | 104 ++++++++++
 tb/tb_gate_truth_table_exerciser.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gate_exerciser_pkg.sv
// gate_exerciser_pkg: shared state encoding and sizing helpers for the gate truth-table exerciser
package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

    function automatic int settle_width(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// gate_settle_timer: counts 0..SETTLE_CYCLES-1 and strobes on the terminal count
module gate_settle_timer
    import gate_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_strobe
);

    localparam int CW = settle_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // free-running settle counter, realigned to zero when a sweep is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clear || r_cnt == LAST) r_cnt <= '0;
        else r_cnt <= r_cnt + CW'(1);
    end

    assign o_strobe = (r_cnt == LAST);

endmodule

// File: rtl/gate_truth_table_exerciser.sv
// gate_truth_table_exerciser: sweeps all gate input vectors and checks the output against a truth table
module gate_truth_table_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [(1<<N_INPUTS)-1:0]  i_expected,
    output logic [N_INPUTS-1:0]       o_dut_in,
    input  logic                      i_dut_out,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_pass,
    output logic [N_INPUTS:0]         o_err_count,
    output logic                      o_first_fail_valid,
    output logic [N_INPUTS-1:0]       o_first_fail_idx
);

    localparam int VECS = vec_count(N_INPUTS);
    localparam int IW   = idx_width(N_INPUTS);

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [VECS-1:0]     r_exp;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [IW-1:0]       r_err;
    logic                r_ffv;
    logic [N_INPUTS-1:0] r_ffi;

    logic                w_strobe;
    logic                w_accept;
    logic                w_sample;
    logic                w_mis;
    logic                w_last;
    logic [IW-1:0]       w_err_next;

    gate_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .o_strobe (w_strobe)
    );

    assign w_accept   = i_start && (r_state != ST_RUN);
    assign w_sample   = (r_state == ST_RUN) && w_strobe;
    assign w_mis      = i_dut_out != r_exp[r_idx[N_INPUTS-1:0]];
    assign w_last     = (r_idx == IW'(VECS - 1));
    assign w_err_next = r_err + IW'(w_mis);

    // sweep FSM: accept start, sample and compare each vector, publish results on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffi   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state <= ST_RUN;
                r_exp   <= i_expected;
                r_idx   <= '0;
                r_busy  <= 1'b1;
                r_pass  <= 1'b0;
                r_err   <= '0;
                r_ffv   <= 1'b0;
                r_ffi   <= '0;
            end else if (w_sample) begin
                r_err <= w_err_next;
                if (w_mis && !r_ffv) begin
                    r_ffv <= 1'b1;
                    r_ffi <= r_idx[N_INPUTS-1:0];
                end
                if (w_last) begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_next == '0);
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign o_dut_in           = r_idx[N_INPUTS-1:0];
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_pass;
    assign o_err_count        = r_err;
    assign o_first_fail_valid = r_ffv;
    assign o_first_fail_idx   = r_ffi;

endmodule

// File: tb/tb_gate_truth_table_exerciser.sv
// tb_gate_truth_table_exerciser: scoreboard bench for the gate truth-table exerciser
module tb_gate_truth_table_exerciser;

    typedef struct packed {
        logic [2:0] err;
        logic       ffv;
        logic [1:0] ffi;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       st1, st2;
    logic [3:0] exp1, exp2;
    logic [1:0] in1, in2, ffi1, ffi2;
    logic       out1, out2, busy1, busy2, done1, done2, pass1, pass2, ffv1, ffv2;
    logic [2:0] err1, err2;

    assign out1 = in1[0] ? in1[1] : 1'b0;
    assign out2 = 1'b1;

    gate_truth_table_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(st1), .i_expected(exp1), .o_dut_in(in1),
        .i_dut_out(out1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_count(err1), .o_first_fail_valid(ffv1), .o_first_fail_idx(ffi1)
    );

    gate_truth_table_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .i_start(st2), .i_expected(exp2), .o_dut_in(in2),
        .i_dut_out(out2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_count(err2), .o_first_fail_valid(ffv2), .o_first_fail_idx(ffi2)
    );

    logic       sel_mon = 1'b0;
    logic       m_busy, m_done;
    logic [1:0] m_in;
    res_t       m_res;
    assign m_busy = sel_mon ? busy2 : busy1;
    assign m_done = sel_mon ? done2 : done1;
    assign m_in   = sel_mon ? in2 : in1;
    assign m_res  = sel_mon ? {err2, ffv2, ffi2, pass2} : {err1, ffv1, ffi1, pass1};

    int checks = 0;
    int failures = 0;
    logic [1:0] q_in[$];
    res_t       q_res[$];

    int   seq_bad;
    int   done_cyc;
    logic o0_busy;
    res_t o0_res;
    res_t f_res;
    res_t want;

    function automatic res_t model(input logic [3:0] e, input bit stuck);
        res_t r = '0;
        for (int k = 0; k < 4; k++) begin
            logic g = stuck ? 1'b1 : (k == 3);
            if (g != e[k]) begin
                r.err = r.err + 3'd1;
                if (!r.ffv) begin
                    r.ffv = 1'b1;
                    r.ffi = 2'(k);
                end
            end
        end
        r.pass = (r.err == 3'd0);
        return r;
    endfunction

    task automatic run(input bit sel, input logic [3:0] e, input bit hold);
        int s = sel ? 2 : 1;
        q_res.push_back(model(e, sel));
        for (int c = 0; c < 4 * s; c++) q_in.push_back(2'(c / s));
        sel_mon = sel;
        @(negedge clk);
        if (sel) begin st2 = 1'b1; exp2 = e; end
        else begin st1 = 1'b1; exp1 = e; end
        @(posedge clk);
        #1;
        if (!hold) begin st1 = 1'b0; st2 = 1'b0; end
        o0_busy  = m_busy;
        o0_res   = m_res;
        seq_bad  = 0;
        done_cyc = -1;
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            if (m_done) done_cyc = c;
            else if (q_in.size() > 0) begin
                if (m_in !== q_in.pop_front()) seq_bad++;
            end else seq_bad++;
            if (done_cyc < 0) begin
                @(posedge clk);
                #1;
            end
        end
        seq_bad += q_in.size();
        q_in.delete();
        f_res = m_res;
        want  = q_res.pop_front();
    endtask

    task automatic test_reset;
        rst = 1'b1; st1 = 1'b0; st2 = 1'b0; exp1 = '0; exp2 = '0;
        #1;
        checks++; if ({in1, busy1, done1, pass1, err1, ffv1, ffi1} !== '0) begin failures++; $display("FAIL reset_dut1 got=%b want=0", {in1, busy1, done1, pass1, err1, ffv1, ffi1}); end
        checks++; if ({in2, busy2, done2, pass2, err2, ffv2, ffi2} !== '0) begin failures++; $display("FAIL reset_dut2 got=%b want=0", {in2, busy2, done2, pass2, err2, ffv2, ffi2}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pass_sweep;
        run(1'b0, 4'b1000, 1'b0);
        checks++; if (o0_busy !== 1'b1) begin failures++; $display("FAIL pass_busy got=%b want=1", o0_busy); end
        checks++; if (seq_bad != 0) begin failures++; $display("FAIL pass_seq bad=%0d want=0", seq_bad); end
        checks++; if (done_cyc != 4) begin failures++; $display("FAIL pass_done_cyc got=%0d want=4", done_cyc); end
        checks++; if (f_res !== want) begin failures++; $display("FAIL pass_result got=%b want=%b", f_res, want); end
        checks++; if (in1 !== 2'd3) begin failures++; $display("FAIL pass_hold_in got=%0d want=3", in1); end
        @(posedge clk);
        #1;
        checks++; if (done1 !== 1'b0 || pass1 !== 1'b1) begin failures++; $display("FAIL pass_after got=%b%b want=01", done1, pass1); end
    endtask

    task automatic test_fail_sweep;
        run(1'b0, 4'b0110, 1'b0);
        checks++; if (done_cyc != 4) begin failures++; $display("FAIL fail_done_cyc got=%0d want=4", done_cyc); end
        checks++; if (f_res !== want) begin failures++; $display("FAIL fail_result got=%b want=%b", f_res, want); end
    endtask

    task automatic test_settle_stuck;
        run(1'b1, 4'b1000, 1'b0);
        checks++; if (seq_bad != 0) begin failures++; $display("FAIL settle_seq bad=%0d want=0", seq_bad); end
        checks++; if (done_cyc != 8) begin failures++; $display("FAIL settle_done_cyc got=%0d want=8", done_cyc); end
        checks++; if (f_res !== want) begin failures++; $display("FAIL settle_result got=%b want=%b", f_res, want); end
    endtask

    task automatic test_start_held;
        run(1'b0, 4'b0110, 1'b1);
        checks++; if (seq_bad != 0) begin failures++; $display("FAIL held_seq bad=%0d want=0", seq_bad); end
        checks++; if (done_cyc != 4) begin failures++; $display("FAIL held_done_cyc got=%0d want=4", done_cyc); end
        checks++; if (f_res !== want) begin failures++; $display("FAIL held_result got=%b want=%b", f_res, want); end
        run(1'b0, 4'b0110, 1'b0);
        checks++; if (o0_res !== '0 || o0_busy !== 1'b1) begin failures++; $display("FAIL held_restart_clear got=%b busy=%b want=0 busy=1", o0_res, o0_busy); end
        checks++; if (seq_bad != 0 || done_cyc != 4) begin failures++; $display("FAIL held_second got=%0d/%0d want=0/4", seq_bad, done_cyc); end
        checks++; if (f_res !== want) begin failures++; $display("FAIL held_second_result got=%b want=%b", f_res, want); end
    endtask

    task automatic test_reset_mid_sweep;
        int dones = 0;
        @(negedge clk);
        st1 = 1'b1; exp1 = 4'b1000;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++; if (in1 !== 2'd2) begin failures++; $display("FAIL rstmid_vec got=%0d want=2", in1); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({in1, busy1, done1, pass1, err1, ffv1, ffi1} !== '0) begin failures++; $display("FAIL rstmid_clear got=%b want=0", {in1, busy1, done1, pass1, err1, ffv1, ffi1}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL rstmid_nodone got=%0d want=0", dones); end
        run(1'b0, 4'b1000, 1'b0);
        checks++; if (done_cyc != 4 || f_res !== want) begin failures++; $display("FAIL rstmid_rerun got=%0d/%b want=4/%b", done_cyc, f_res, want); end
    endtask

    task automatic test_back_to_back;
        run(1'b0, 4'b0000, 1'b0);
        checks++; if (f_res !== want) begin failures++; $display("FAIL b2b_first got=%b want=%b", f_res, want); end
        run(1'b0, 4'b1000, 1'b0);
        checks++; if (o0_res.err !== 3'd0 || o0_res.ffv !== 1'b0 || o0_busy !== 1'b1) begin failures++; $display("FAIL b2b_clear got=%b busy=%b want=0 busy=1", o0_res, o0_busy); end
        checks++; if (done_cyc != 4 || f_res !== want) begin failures++; $display("FAIL b2b_second got=%0d/%b want=4/%b", done_cyc, f_res, want); end
    endtask

    initial begin
        test_reset;
        test_pass_sweep;
        test_fail_sweep;
        test_settle_stuck;
        test_start_held;
        test_reset_mid_sweep;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
